// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse keyer types, timing constants and pattern helper
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MARK,
    S_ELEM_GAP,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int ELEM_GAP_UNITS   = 1;
  localparam int CHAR_GAP_UNITS   = 3;
  localparam int WORD_EXTRA_UNITS = 4;
  localparam int MAX_ELEMS        = 5;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef struct packed {
    logic       valid;
    logic       is_space;
    logic [2:0] len;
    logic [4:0] pattern;
  } morse_code_t;

  // Table entries are written in send order (first element in bit len-1);
  // the keyer wants element i in bit i.
  function automatic logic [4:0] seq_to_pattern(input logic [2:0] len, input logic [4:0] seq);
    logic [4:0] rev;
    rev = {seq[0], seq[1], seq[2], seq[3], seq[4]};
    return rev >> (3'd5 - len);
  endfunction

endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - combinational ASCII to Morse lookup with lowercase folding
module morse_lut
  import morse_pkg::*;
(
  input  logic [7:0]  i_char,
  output morse_code_t o_code
);

  logic [7:0] w_upper;
  logic [7:0] w_ls;

  assign w_upper = (i_char >= 8'h61 && i_char <= 8'h7A) ? (i_char - 8'h20) : i_char;

  // w_ls = {len, send-order sequence right aligned}; 1 = dash
  always_comb begin
    w_ls = 8'h00;
    case (w_upper)
      "A": w_ls = {3'd2, 5'b00001};
      "B": w_ls = {3'd4, 5'b01000};
      "C": w_ls = {3'd4, 5'b01010};
      "D": w_ls = {3'd3, 5'b00100};
      "E": w_ls = {3'd1, 5'b00000};
      "F": w_ls = {3'd4, 5'b00010};
      "G": w_ls = {3'd3, 5'b00110};
      "H": w_ls = {3'd4, 5'b00000};
      "I": w_ls = {3'd2, 5'b00000};
      "J": w_ls = {3'd4, 5'b00111};
      "K": w_ls = {3'd3, 5'b00101};
      "L": w_ls = {3'd4, 5'b00100};
      "M": w_ls = {3'd2, 5'b00011};
      "N": w_ls = {3'd2, 5'b00010};
      "O": w_ls = {3'd3, 5'b00111};
      "P": w_ls = {3'd4, 5'b00110};
      "Q": w_ls = {3'd4, 5'b01101};
      "R": w_ls = {3'd3, 5'b00010};
      "S": w_ls = {3'd3, 5'b00000};
      "T": w_ls = {3'd1, 5'b00001};
      "U": w_ls = {3'd3, 5'b00001};
      "V": w_ls = {3'd4, 5'b00001};
      "W": w_ls = {3'd3, 5'b00011};
      "X": w_ls = {3'd4, 5'b01001};
      "Y": w_ls = {3'd4, 5'b01011};
      "Z": w_ls = {3'd4, 5'b01100};
      "0": w_ls = {3'd5, 5'b11111};
      "1": w_ls = {3'd5, 5'b01111};
      "2": w_ls = {3'd5, 5'b00111};
      "3": w_ls = {3'd5, 5'b00011};
      "4": w_ls = {3'd5, 5'b00001};
      "5": w_ls = {3'd5, 5'b00000};
      "6": w_ls = {3'd5, 5'b10000};
      "7": w_ls = {3'd5, 5'b11000};
      "8": w_ls = {3'd5, 5'b11100};
      "9": w_ls = {3'd5, 5'b11110};
      default: w_ls = 8'h00;
    endcase
  end

  assign o_code.valid    = (w_ls[7:5] != 3'd0);
  assign o_code.is_space = (i_char == ASCII_SPACE);
  assign o_code.len      = w_ls[7:5];
  assign o_code.pattern  = seq_to_pattern(w_ls[7:5], w_ls[4:0]);

endmodule

// File: rtl/morse_tx_keyer.sv
// rtl/morse_tx_keyer.sv - pops ASCII from the input FIFO and keys it out as Morse
module morse_tx_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  key_out,
  output logic                  busy,
  output logic                  char_done,
  output logic                  bad_char
);

  localparam int CW = $clog2(UNIT_CYCLES);

  state_t      r_state;
  state_t      w_next_state;
  logic [CW-1:0] r_cyc_cnt;
  logic [1:0]  r_unit_cnt;
  logic [2:0]  r_len;
  logic [4:0]  r_pattern;
  logic [2:0]  r_elem_idx;
  logic        r_key;

  morse_code_t w_code;
  logic        w_last_cycle;
  logic        w_more_elems;
  logic        w_next_dash;
  logic [4:0]  w_next_shift;
  logic [1:0]  w_next_units;
  logic        w_timed;

  morse_lut u_lut (
    .i_char (fifo_data[7:0]),
    .o_code (w_code)
  );

  assign w_last_cycle = (r_cyc_cnt == CW'(UNIT_CYCLES - 1)) && (r_unit_cnt == 2'd0);
  assign w_more_elems = (r_elem_idx + 3'd1) < r_len;
  assign w_next_shift = r_pattern >> (r_elem_idx + 3'd1);
  assign w_next_dash  = (r_state == S_LOAD) ? w_code.pattern[0] : w_next_shift[0];
  assign w_timed      = (r_state != S_IDLE) && (r_state != S_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (enable && !fifo_empty) w_next_state = S_LOAD;
      S_LOAD: begin
        if (w_code.valid)         w_next_state = S_MARK;
        else if (w_code.is_space) w_next_state = S_WORD_GAP;
        else                      w_next_state = S_IDLE;
      end
      S_MARK:     if (w_last_cycle) w_next_state = w_more_elems ? S_ELEM_GAP : S_CHAR_GAP;
      S_ELEM_GAP: if (w_last_cycle) w_next_state = S_MARK;
      S_CHAR_GAP: if (w_last_cycle) w_next_state = S_IDLE;
      S_WORD_GAP: if (w_last_cycle) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = (r_state == S_IDLE) && enable && !fifo_empty;
    busy      = (r_state != S_IDLE);
    bad_char  = (r_state == S_LOAD) && !w_code.valid && !w_code.is_space;
    char_done = bad_char ||
                (((r_state == S_CHAR_GAP) || (r_state == S_WORD_GAP)) && w_last_cycle);
    key_out   = r_key;
  end

  // Counters hold units-1 so a 4-unit word gap still fits in two bits.
  always_comb begin
    w_next_units = 2'd0;
    case (w_next_state)
      S_MARK:     w_next_units = w_next_dash ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
      S_ELEM_GAP: w_next_units = 2'(ELEM_GAP_UNITS - 1);
      S_CHAR_GAP: w_next_units = 2'(CHAR_GAP_UNITS - 1);
      S_WORD_GAP: w_next_units = 2'(WORD_EXTRA_UNITS - 1);
      default:    w_next_units = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt  <= '0;
      r_unit_cnt <= '0;
      r_len      <= '0;
      r_pattern  <= '0;
      r_elem_idx <= '0;
      r_key      <= 1'b0;
    end else begin
      r_key <= (w_next_state == S_MARK);
      if (w_next_state != r_state) begin
        r_cyc_cnt  <= '0;
        r_unit_cnt <= w_next_units;
      end else if (w_timed) begin
        if (r_cyc_cnt == CW'(UNIT_CYCLES - 1)) begin
          r_cyc_cnt  <= '0;
          r_unit_cnt <= r_unit_cnt - 2'd1;
        end else begin
          r_cyc_cnt <= r_cyc_cnt + CW'(1);
        end
      end
      if (r_state == S_LOAD && w_code.valid) begin
        r_len      <= w_code.len;
        r_pattern  <= w_code.pattern;
        r_elem_idx <= '0;
      end else if (r_state == S_ELEM_GAP && w_next_state == S_MARK) begin
        r_elem_idx <= r_elem_idx + 3'd1;
      end
    end
  end

endmodule
